mem_issue_queue: RTL and testbench

- In-order issue queue for the memory pipe; sits directly upstream of the memory execute block.
- Accepts dispatched load/store/atomic/cacop micro-ops from rename/dispatch and holds them until both source physical registers are ready.
- Issues strictly oldest-first, so memory ordering is preserved; the issue handshake is driven by the memory block's exe-ready signal.
- Register read and payload expansion happen downstream; this block stores only the opaque payload and the source tags.

---
 rtl/mem_issue_queue_pkg.sv | 20 ++
 rtl/mem_iq_wakeup_match.sv | 23 ++
 rtl/mem_issue_queue.sv | 151 +++++++++++++++
 tb/tb_mem_issue_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_issue_queue_pkg.sv
// Shared memory-pipe definitions: issue-queue entry layout and the default
// widths used by dispatch and the memory issue queue.
package mem_issue_queue_pkg;

  localparam int MEM_IQ_DEPTH      = 8;
  localparam int MEM_IQ_PREG_W     = 6;
  localparam int MEM_IQ_ROB_IDX_W  = 6;
  localparam int MEM_IQ_PAYLOAD_W  = 64;
  localparam int MEM_IQ_WAKEUP_NUM = 4;

  typedef struct packed {
    logic                        valid;
    logic [MEM_IQ_PREG_W-1:0]    psrc0;
    logic                        rdy0;
    logic [MEM_IQ_PREG_W-1:0]    psrc1;
    logic                        rdy1;
    logic [MEM_IQ_PAYLOAD_W-1:0] payload;
  } MemIqEntrySt;

endpackage

// File: rtl/mem_iq_wakeup_match.sv
// Combinational comparator: does a source tag match any valid wakeup port.
module mem_iq_wakeup_match
  import mem_issue_queue_pkg::*;
#(
  parameter int PREG_W     = MEM_IQ_PREG_W,
  parameter int WAKEUP_NUM = MEM_IQ_WAKEUP_NUM
) (
  input  logic [PREG_W-1:0]            tag_i,
  input  logic [WAKEUP_NUM-1:0]        wkup_valid_i,
  input  logic [WAKEUP_NUM*PREG_W-1:0] wkup_preg_i,
  output logic                         match_o
);

  always_comb begin
    match_o = 1'b0;
    for (int k = 0; k < WAKEUP_NUM; k++) begin
      if (wkup_valid_i[k] && (wkup_preg_i[k*PREG_W +: PREG_W] == tag_i)) begin
        match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory-pipe issue queue: holds dispatched micro-ops until both
// sources are ready and issues strictly from the head.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH      = MEM_IQ_DEPTH,
  parameter int PREG_W     = MEM_IQ_PREG_W,
  parameter int PAYLOAD_W  = MEM_IQ_PAYLOAD_W,
  parameter int WAKEUP_NUM = MEM_IQ_WAKEUP_NUM
) (
  input  logic                         clk,
  input  logic                         a_rst_n,
  input  logic                         flush_i,
  input  logic                         dis_valid_i,
  output logic                         dis_ready_o,
  input  logic [PREG_W-1:0]            dis_psrc0_i,
  input  logic                         dis_psrc0_rdy_i,
  input  logic [PREG_W-1:0]            dis_psrc1_i,
  input  logic                         dis_psrc1_rdy_i,
  input  logic [PAYLOAD_W-1:0]         dis_payload_i,
  input  logic [WAKEUP_NUM-1:0]        wkup_valid_i,
  input  logic [WAKEUP_NUM*PREG_W-1:0] wkup_preg_i,
  output logic                         iss_valid_o,
  input  logic                         iss_ready_i,
  output logic [PREG_W-1:0]            iss_psrc0_o,
  output logic [PREG_W-1:0]            iss_psrc1_o,
  output logic [PAYLOAD_W-1:0]         iss_payload_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic [PREG_W-1:0]    psrc0;
    logic [PREG_W-1:0]    psrc1;
    logic [PAYLOAD_W-1:0] payload;
  } slot_t;

  slot_t            slot_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rdy0_q, rdy0_d;
  logic [DEPTH-1:0] rdy1_q, rdy1_d;
  logic [DEPTH-1:0] ent_wake0, ent_wake1;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full, empty, enq, deq;
  logic             dis_wake0, dis_wake1, dis_rdy0, dis_rdy1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent_match
    mem_iq_wakeup_match #(.PREG_W(PREG_W), .WAKEUP_NUM(WAKEUP_NUM)) u_match0 (
      .tag_i        (slot_q[i].psrc0),
      .wkup_valid_i (wkup_valid_i),
      .wkup_preg_i  (wkup_preg_i),
      .match_o      (ent_wake0[i])
    );
    mem_iq_wakeup_match #(.PREG_W(PREG_W), .WAKEUP_NUM(WAKEUP_NUM)) u_match1 (
      .tag_i        (slot_q[i].psrc1),
      .wkup_valid_i (wkup_valid_i),
      .wkup_preg_i  (wkup_preg_i),
      .match_o      (ent_wake1[i])
    );
  end

  mem_iq_wakeup_match #(.PREG_W(PREG_W), .WAKEUP_NUM(WAKEUP_NUM)) u_dis_match0 (
    .tag_i        (dis_psrc0_i),
    .wkup_valid_i (wkup_valid_i),
    .wkup_preg_i  (wkup_preg_i),
    .match_o      (dis_wake0)
  );
  mem_iq_wakeup_match #(.PREG_W(PREG_W), .WAKEUP_NUM(WAKEUP_NUM)) u_dis_match1 (
    .tag_i        (dis_psrc1_i),
    .wkup_valid_i (wkup_valid_i),
    .wkup_preg_i  (wkup_preg_i),
    .match_o      (dis_wake1)
  );

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);
  assign empty    = (head_q == tail_q);

  // Handshakes depend only on registered state, so a dequeue never frees a
  // slot for a dispatch in the same cycle.
  assign dis_ready_o = ~full;
  assign enq         = dis_valid_i & ~full & ~flush_i;
  assign iss_valid_o = ~empty & rdy0_q[head_idx] & rdy1_q[head_idx] & ~flush_i;
  assign deq         = iss_valid_o & iss_ready_i;

  assign iss_psrc0_o   = slot_q[head_idx].psrc0;
  assign iss_psrc1_o   = slot_q[head_idx].psrc1;
  assign iss_payload_o = slot_q[head_idx].payload;
  assign count_o       = tail_q - head_q;

  // Preg 0 is hardwired ready; a same-cycle wakeup is captured at dispatch.
  assign dis_rdy0 = dis_psrc0_rdy_i | (dis_psrc0_i == '0) | dis_wake0;
  assign dis_rdy1 = dis_psrc1_rdy_i | (dis_psrc1_i == '0) | dis_wake1;

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    rdy0_d  = rdy0_q | (valid_q & ent_wake0);
    rdy1_d  = rdy1_q | (valid_q & ent_wake1);
    if (flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (deq) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + PTR_W'(1);
      end
      if (enq) begin
        valid_d[tail_idx] = 1'b1;
        rdy0_d[tail_idx]  = dis_rdy0;
        rdy1_d[tail_idx]  = dis_rdy1;
        tail_d            = tail_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      valid_q <= '0;
      rdy0_q  <= '0;
      rdy1_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // NOTE: tag/payload storage has no reset; it is only read behind valid
  // state, and leaving it unreset keeps it a plain RAM-style array.
  always_ff @(posedge clk) begin
    if (enq) begin
      slot_q[tail_idx] <= slot_t'{psrc0:   dis_psrc0_i,
                                  psrc1:   dis_psrc1_i,
                                  payload: dis_payload_i};
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_mem_issue_queue;

  localparam int DEPTH      = 8;
  localparam int PREG_W     = 6;
  localparam int PAYLOAD_W  = 64;
  localparam int WAKEUP_NUM = 4;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic                         clk = 1'b0;
  logic                         a_rst_n;
  logic                         flush_i;
  logic                         dis_valid_i;
  logic                         dis_ready_o;
  logic [PREG_W-1:0]            dis_psrc0_i;
  logic                         dis_psrc0_rdy_i;
  logic [PREG_W-1:0]            dis_psrc1_i;
  logic                         dis_psrc1_rdy_i;
  logic [PAYLOAD_W-1:0]         dis_payload_i;
  logic [WAKEUP_NUM-1:0]        wkup_valid_i;
  logic [WAKEUP_NUM*PREG_W-1:0] wkup_preg_i;
  logic                         iss_valid_o;
  logic                         iss_ready_i;
  logic [PREG_W-1:0]            iss_psrc0_o;
  logic [PREG_W-1:0]            iss_psrc1_o;
  logic [PAYLOAD_W-1:0]         iss_payload_o;
  logic [CNT_W-1:0]             count_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [PREG_W-1:0]    p0;
    logic [PREG_W-1:0]    p1;
    bit                   r0;
    bit                   r1;
    logic [PAYLOAD_W-1:0] pl;
  } ent_t;

  ent_t mq[$];

  mem_issue_queue #(
    .DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W), .WAKEUP_NUM(WAKEUP_NUM)
  ) dut (
    .clk             (clk),
    .a_rst_n         (a_rst_n),
    .flush_i         (flush_i),
    .dis_valid_i     (dis_valid_i),
    .dis_ready_o     (dis_ready_o),
    .dis_psrc0_i     (dis_psrc0_i),
    .dis_psrc0_rdy_i (dis_psrc0_rdy_i),
    .dis_psrc1_i     (dis_psrc1_i),
    .dis_psrc1_rdy_i (dis_psrc1_rdy_i),
    .dis_payload_i   (dis_payload_i),
    .wkup_valid_i    (wkup_valid_i),
    .wkup_preg_i     (wkup_preg_i),
    .iss_valid_o     (iss_valid_o),
    .iss_ready_i     (iss_ready_i),
    .iss_psrc0_o     (iss_psrc0_o),
    .iss_psrc1_o     (iss_psrc1_o),
    .iss_payload_o   (iss_payload_o),
    .count_o         (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit woke(input logic [PREG_W-1:0] tag);
    for (int k = 0; k < WAKEUP_NUM; k++)
      if (wkup_valid_i[k] && wkup_preg_i[k*PREG_W +: PREG_W] == tag) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    flush_i = 0; dis_valid_i = 0; iss_ready_i = 0; wkup_valid_i = '0; wkup_preg_i = '0;
    dis_psrc0_i = '0; dis_psrc1_i = '0; dis_psrc0_rdy_i = 0; dis_psrc1_rdy_i = 0;
    dis_payload_i = '0;
  endtask

  task automatic dispatch(input int p0, input bit r0, input int p1, input bit r1);
    dis_valid_i     = 1;
    dis_psrc0_i     = PREG_W'(p0);
    dis_psrc0_rdy_i = r0;
    dis_psrc1_i     = PREG_W'(p1);
    dis_psrc1_rdy_i = r1;
    dis_payload_i   = {$urandom, $urandom};
  endtask

  task automatic set_wkup(input int port, input int tag);
    wkup_valid_i[port]                 = 1'b1;
    wkup_preg_i[port*PREG_W +: PREG_W] = PREG_W'(tag);
  endtask

  // Called at a falling edge with inputs applied: compare outputs against the
  // model, then advance the model across the next rising edge.
  task automatic step();
    bit   exp_v, do_enq, do_deq;
    ent_t e;
    #1;
    check("count", 64'(count_o), 64'(mq.size()));
    check("dis_ready", 64'(dis_ready_o), 64'(mq.size() < DEPTH));
    exp_v = (mq.size() > 0) && mq[0].r0 && mq[0].r1 && !flush_i;
    check("iss_valid", 64'(iss_valid_o), 64'(exp_v));
    if (exp_v) begin
      check("iss_psrc0", 64'(iss_psrc0_o), 64'(mq[0].p0));
      check("iss_psrc1", 64'(iss_psrc1_o), 64'(mq[0].p1));
      check("iss_payload", iss_payload_o, mq[0].pl);
    end
    @(posedge clk);
    if (flush_i) begin
      mq.delete();
    end else begin
      do_deq = exp_v && iss_ready_i;
      do_enq = dis_valid_i && (mq.size() < DEPTH);
      foreach (mq[i]) begin
        if (woke(mq[i].p0)) mq[i].r0 = 1;
        if (woke(mq[i].p1)) mq[i].r1 = 1;
      end
      if (do_deq) void'(mq.pop_front());
      if (do_enq) begin
        e.p0 = dis_psrc0_i;
        e.p1 = dis_psrc1_i;
        e.pl = dis_payload_i;
        e.r0 = dis_psrc0_rdy_i || (dis_psrc0_i == '0) || woke(dis_psrc0_i);
        e.r1 = dis_psrc1_rdy_i || (dis_psrc1_i == '0) || woke(dis_psrc1_i);
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int phase;
    idle();
    a_rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_dis_ready", 64'(dis_ready_o), 64'd1);
    check("rst_iss_valid", 64'(iss_valid_o), 64'd0);
    a_rst_n = 1;
    @(negedge clk);

    // Zero tag plus ready source issues the following cycle.
    dispatch(0, 0, 5, 1); step();
    idle(); step();
    iss_ready_i = 1; step();
    idle(); step();

    // Wakeup on port 2 makes the head issuable one cycle later.
    dispatch(12, 0, 0, 0); step();
    idle(); iss_ready_i = 1; step();
    set_wkup(2, 12); step();
    wkup_valid_i = '0; step();
    step();

    // Fill to capacity, then dispatch alongside an accepted issue.
    idle();
    for (int i = 0; i < DEPTH; i++) begin dispatch(i + 1, 1, 0, 0); step(); end
    check("full_count", 64'(count_o), 64'(DEPTH));
    check("full_dis_ready", 64'(dis_ready_o), 64'd0);
    dispatch(3, 1, 3, 1); iss_ready_i = 1; step();
    idle(); step();
    iss_ready_i = 1; repeat (DEPTH) step();

    // Head blocked while the younger entry is ready: no bypass.
    idle();
    dispatch(20, 0, 0, 0); step();
    dispatch(0, 1, 0, 1); step();
    idle(); iss_ready_i = 1; step(); step();
    set_wkup(0, 20); step();
    wkup_valid_i = '0; repeat (3) step();

    // Streaming enqueue/dequeue wraps the pointers.
    idle();
    for (int i = 0; i < 20; i++) begin dispatch(0, 0, i % 3, 1); iss_ready_i = 1; step(); end
    idle(); iss_ready_i = 1; repeat (3) step();

    // Flush with five entries during both handshakes.
    idle();
    for (int i = 0; i < 5; i++) begin dispatch(0, 1, 0, 1); step(); end
    dispatch(7, 1, 7, 1); iss_ready_i = 1; flush_i = 1; step();
    idle(); step();
    check("flush_count", 64'(count_o), 64'd0);

    // Randomised traffic in fill-heavy, drain-heavy and balanced phases.
    for (int c = 0; c < 1500; c++) begin
      phase = (c / 40) % 3;
      idle();
      if ($urandom_range(99) < (phase == 0 ? 85 : phase == 1 ? 25 : 55))
        dispatch($urandom_range(15), $urandom_range(99) < 40,
                 $urandom_range(15), $urandom_range(99) < 40);
      iss_ready_i = $urandom_range(99) < (phase == 0 ? 30 : phase == 1 ? 90 : 65);
      for (int k = 0; k < WAKEUP_NUM; k++)
        if ($urandom_range(99) < 25) set_wkup(k, $urandom_range(15));
      flush_i = ($urandom_range(199) == 0);
      step();
      if (c == 777) begin
        idle();
        a_rst_n = 0;
        #2;
        mq.delete();
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_dis_ready", 64'(dis_ready_o), 64'd1);
        check("arst_iss_valid", 64'(iss_valid_o), 64'd0);
        a_rst_n = 1;
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
